// File: rtl/lmac_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lmac_rx_fifo
//  Purpose  : Receive-direction quad-word FIFO between the MAC RX datapath
//             (writer) and the host-side reader. Provides registered read
//             data with a one-cycle valid strobe, full/empty/almost-full
//             status, a used-entry count, and sticky overflow plus a
//             saturating drop counter for writes refused while full.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             RX_DATA, RX_WE       - write side (MAC RX datapath)
//             RX_RE                - read request (host side)
//             OVF_CLR              - clears overflow flag and drop counter
//             RXFIFO_RD_DATA/VALID - registered read data and strobe
//             RXFIFO_EMPTY/FULL/AFULL, RXFIFO_RUSED_QWD - occupancy status
//             RXFIFO_OVERFLOW, RXFIFO_DROP_CNT          - drop accounting
//  Revision : 1.0 - initial release
// ============================================================================
module lmac_rx_fifo #(
    parameter int DATA_W       = 64,
    parameter int DEPTH        = 16,
    parameter int PTR_W        = 4,
    parameter int CNT_W        = 13,
    parameter int AFULL_THRESH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_WE,
    input  logic              RX_RE,
    input  logic              OVF_CLR,
    output logic [DATA_W-1:0] RXFIFO_RD_DATA,
    output logic              RXFIFO_RD_VALID,
    output logic              RXFIFO_EMPTY,
    output logic              RXFIFO_FULL,
    output logic              RXFIFO_AFULL,
    output logic [CNT_W-1:0]  RXFIFO_RUSED_QWD,
    output logic              RXFIFO_OVERFLOW,
    output logic [15:0]       RXFIFO_DROP_CNT
);

    // Count needs one extra bit over the pointers to represent DEPTH itself.
    localparam logic [PTR_W:0] c_depth  = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0] c_afull  = AFULL_THRESH[PTR_W:0];
    localparam logic [15:0]    c_cnt_max = 16'hFFFF;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [PTR_W:0]    count_q,    count_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              empty_q,    empty_d;
    logic              full_q,     full_d;
    logic              afull_q,    afull_d;
    logic              ovf_q,      ovf_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              rd_acc;
    logic              wr_acc;
    logic              wr_drop;

    // A read is never bypassed from the write port, so an empty FIFO rejects
    // the read even if a write lands in the same cycle. A write into a full
    // FIFO is allowed only when a read frees an entry in that same cycle.
    always_comb begin
        rd_acc  = RX_RE & ~empty_q;
        wr_acc  = RX_WE & (~full_q | rd_acc);
        wr_drop = RX_WE & full_q & ~rd_acc;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        if (rd_acc) begin
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + 1'b1;
        end

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end

        // Clear first so that a drop in the same cycle restarts the count at 1.
        if (OVF_CLR) begin
            ovf_d      = 1'b0;
            drop_cnt_d = 16'h0000;
        end
        if (wr_drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_d != c_cnt_max) begin
                drop_cnt_d = drop_cnt_d + 16'h0001;
            end
        end

        // Flags follow the next count so they line up with RXFIFO_RUSED_QWD.
        empty_d = (count_d == '0);
        full_d  = (count_d == c_depth);
        afull_d = (count_d >= c_afull);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 16'h0000;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; a write presented during reset is discarded.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= RX_DATA;
        end
    end

    assign RXFIFO_RD_DATA   = rd_data_q;
    assign RXFIFO_RD_VALID  = rd_valid_q;
    assign RXFIFO_EMPTY     = empty_q;
    assign RXFIFO_FULL      = full_q;
    assign RXFIFO_AFULL     = afull_q;
    assign RXFIFO_RUSED_QWD = {{(CNT_W-PTR_W-1){1'b0}}, count_q};
    assign RXFIFO_OVERFLOW  = ovf_q;
    assign RXFIFO_DROP_CNT  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lmac_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lmac_rx_fifo
//  Purpose  : Self-checking bench for lmac_rx_fifo. A queue-based reference
//             model tracks contents, read data/strobe and drop accounting;
//             every cycle all DUT outputs are compared to it. Directed
//             sequences cover the listed scenarios, followed by biased
//             random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lmac_rx_fifo;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 13;
    localparam int AFULL  = 12;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] RX_DATA;
    logic              RX_WE;
    logic              RX_RE;
    logic              OVF_CLR;
    logic [DATA_W-1:0] RXFIFO_RD_DATA;
    logic              RXFIFO_RD_VALID;
    logic              RXFIFO_EMPTY;
    logic              RXFIFO_FULL;
    logic              RXFIFO_AFULL;
    logic [CNT_W-1:0]  RXFIFO_RUSED_QWD;
    logic              RXFIFO_OVERFLOW;
    logic [15:0]       RXFIFO_DROP_CNT;

    lmac_rx_fifo dut (
        .clk              (clk),
        .rst              (rst),
        .RX_DATA          (RX_DATA),
        .RX_WE            (RX_WE),
        .RX_RE            (RX_RE),
        .OVF_CLR          (OVF_CLR),
        .RXFIFO_RD_DATA   (RXFIFO_RD_DATA),
        .RXFIFO_RD_VALID  (RXFIFO_RD_VALID),
        .RXFIFO_EMPTY     (RXFIFO_EMPTY),
        .RXFIFO_FULL      (RXFIFO_FULL),
        .RXFIFO_AFULL     (RXFIFO_AFULL),
        .RXFIFO_RUSED_QWD (RXFIFO_RUSED_QWD),
        .RXFIFO_OVERFLOW  (RXFIFO_OVERFLOW),
        .RXFIFO_DROP_CNT  (RXFIFO_DROP_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_rd_data;
    logic              m_rd_valid;
    logic              m_ovf;
    logic [15:0]       m_drop;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        chk("rused",    64'(RXFIFO_RUSED_QWD), 64'(m_q.size()));
        chk("empty",    64'(RXFIFO_EMPTY),     64'(m_q.size() == 0));
        chk("full",     64'(RXFIFO_FULL),      64'(m_q.size() == DEPTH));
        chk("afull",    64'(RXFIFO_AFULL),     64'(m_q.size() >= AFULL));
        chk("rd_valid", 64'(RXFIFO_RD_VALID),  64'(m_rd_valid));
        chk("rd_data",  RXFIFO_RD_DATA,        m_rd_data);
        chk("overflow", 64'(RXFIFO_OVERFLOW),  64'(m_ovf));
        chk("drop_cnt", 64'(RXFIFO_DROP_CNT),  64'(m_drop));
    endtask

    // One clock cycle: drive inputs, advance the model on the edge, then
    // compare all outputs shortly after the edge.
    task automatic step(input logic we, input logic re, input logic clr,
                        input logic r, input logic [DATA_W-1:0] d);
        bit full_now, empty_now, racc, wacc, wdrop;
        RX_WE   = we;
        RX_RE   = re;
        OVF_CLR = clr;
        rst     = r;
        RX_DATA = d;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
            m_drop     = 16'h0000;
        end else begin
            full_now  = (m_q.size() == DEPTH);
            empty_now = (m_q.size() == 0);
            racc  = re && !empty_now;
            wacc  = we && (!full_now || racc);
            wdrop = we && full_now && !racc;
            if (racc) begin
                m_rd_data  = m_q.pop_front();
                m_rd_valid = 1'b1;
            end else begin
                m_rd_valid = 1'b0;
            end
            if (wacc) m_q.push_back(d);
            if (clr) begin
                m_ovf  = 1'b0;
                m_drop = 16'h0000;
            end
            if (wdrop) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'h0001;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic wr(input logic [DATA_W-1:0] d);
        step(1'b1, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic rd();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) rd();
    endtask

    initial begin
        int p_we, p_re;
        logic [DATA_W-1:0] rnd;
        RX_WE = 1'b0; RX_RE = 1'b0; OVF_CLR = 1'b0; rst = 1'b1; RX_DATA = '0;
        m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_drop = 16'h0000;

        // 1. Reset then idle
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        idle();
        chk("t1_empty", 64'(RXFIFO_EMPTY), 64'd1);
        chk("t1_rused", 64'(RXFIFO_RUSED_QWD), 64'd0);

        // 2. Fill with 1..16, then read all back
        for (int i = 1; i <= DEPTH; i++) begin
            wr(64'(i));
            chk("t2_afull_step", 64'(RXFIFO_AFULL), 64'(i >= AFULL));
        end
        chk("t2_full", 64'(RXFIFO_FULL), 64'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            rd();
            chk("t2_rdata", RXFIFO_RD_DATA, 64'(i));
        end
        idle();
        chk("t2_empty", 64'(RXFIFO_EMPTY), 64'd1);

        // 3. Overflow: three drops, then clear
        for (int i = 0; i < DEPTH; i++) wr(64'h100 + 64'(i));
        for (int i = 0; i < 3; i++) wr(64'hDEAD0 + 64'(i));
        chk("t3_drop", 64'(RXFIFO_DROP_CNT), 64'd3);
        chk("t3_ovf", 64'(RXFIFO_OVERFLOW), 64'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("t3_clr", 64'(RXFIFO_DROP_CNT), 64'd0);
        // Clear coinciding with a drop: the drop wins
        step(1'b1, 1'b0, 1'b1, 1'b0, 64'hBAD);
        chk("t3_clr_drop", 64'(RXFIFO_DROP_CNT), 64'd1);

        // 4. Full with simultaneous read/write of 0xAA
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'hAA);
        chk("t4_rused", 64'(RXFIFO_RUSED_QWD), 64'd16);
        chk("t4_rdata", RXFIFO_RD_DATA, 64'h100);
        for (int i = 0; i < DEPTH; i++) rd();
        chk("t4_last", RXFIFO_RD_DATA, 64'hAA);
        idle();

        // 5. Empty with simultaneous read/write of 0x55
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'h55);
        chk("t5_valid", 64'(RXFIFO_RD_VALID), 64'd0);
        rd();
        chk("t5_rdata", RXFIFO_RD_DATA, 64'h55);

        // 6. Pointer wrap then mid-stream reset
        for (int i = 0; i < 10; i++) wr(64'h600 + 64'(i));
        for (int i = 0; i < 10; i++) rd();
        for (int i = 0; i < 12; i++) wr(64'h700 + 64'(i));
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'hFFFF);
        chk("t6_rst_rused", 64'(RXFIFO_RUSED_QWD), 64'd0);
        wr(64'h77);
        rd();
        chk("t6_rdata", RXFIFO_RD_DATA, 64'h77);
        idle();

        // Random traffic in phases of differing write/read bias
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: begin p_we = 80; p_re = 30; end
                1: begin p_we = 50; p_re = 50; end
                2: begin p_we = 90; p_re = 85; end
                default: begin p_we = 25; p_re = 75; end
            endcase
            for (int i = 0; i < 500; i++) begin
                rnd = {$urandom(), $urandom()};
                step(1'($urandom_range(99) < p_we),
                     1'($urandom_range(99) < p_re),
                     1'($urandom_range(99) < 3),
                     1'($urandom_range(999) < 5),
                     rnd);
            end
        end
        drain();

        RX_WE = 1'b0; RX_RE = 1'b0; OVF_CLR = 1'b0; rst = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lmac_rx_fifo.md
Name: lmac_rx_fifo

Overview:
Receive-direction quad-word FIFO for the LMAC core. It sits between the MAC RX datapath, which writes 64-bit quad-words, and the host-side reader, which pops them. It mirrors the TX FIFO in the opposite direction and adds:
- explicit full/empty/almost-full status
- used-count reporting
- registered read data with a valid strobe
- sticky overflow and drop accounting

Parameters:
DATA_W, 64, width of one quad-word entry
DEPTH, 16, number of entries (power of two)
PTR_W, 4, pointer width, log2(DEPTH)
CNT_W, 13, width of RXFIFO_RUSED_QWD
AFULL_THRESH, 12, RXFIFO_AFULL asserts when used count >= this value

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
RX_DATA  in  DATA_W  quad-word from MAC RX datapath
RX_WE  in  1  write request from MAC RX datapath
RX_RE  in  1  read request from host side
OVF_CLR  in  1  clears RXFIFO_OVERFLOW and RXFIFO_DROP_CNT
RXFIFO_RD_DATA  out  DATA_W  registered read data
RXFIFO_RD_VALID  out  1  one-cycle strobe; RXFIFO_RD_DATA updated this cycle
RXFIFO_EMPTY  out  1  used count == 0
RXFIFO_FULL  out  1  used count == DEPTH
RXFIFO_AFULL  out  1  used count >= AFULL_THRESH
RXFIFO_RUSED_QWD  out  CNT_W  entries currently stored
RXFIFO_OVERFLOW  out  1  sticky; a write was dropped
RXFIFO_DROP_CNT  out  16  dropped writes, saturating at 16'hFFFF

Behaviour:
- Reset (rst=1 at a clock edge):
  - pointers, count, RD_DATA, RD_VALID, OVERFLOW and DROP_CNT go to 0.
  - EMPTY=1, FULL=0, AFULL=0.
  - Buffer contents are not reset.
  - Reset mid-operation discards all stored entries; any request in the reset cycle is ignored.
- Storage: DEPTH x DATA_W array. wr_ptr and rd_ptr are PTR_W bits and wrap DEPTH-1 -> 0 naturally.
- Read accept: rd_acc = RX_RE & ~EMPTY.
  - On rd_acc: RD_DATA <= mem[rd_ptr]; RD_VALID <= 1; rd_ptr++.
  - Otherwise RD_VALID <= 0 and RD_DATA holds its value.
  - Read latency is 1 cycle from the accepting edge.
- Write accept: wr_acc = RX_WE & (~FULL | rd_acc).
  - A write while full is accepted only when a read is accepted in the same cycle.
  - On wr_acc: mem[wr_ptr] <= RX_DATA; wr_ptr++.
- Dropped write: wr_drop = RX_WE & FULL & ~rd_acc.
  - Sets OVERFLOW.
  - Increments DROP_CNT, saturating.
  - Pointers and count are unchanged.
- Count update:
  - wr_acc only: +1
  - rd_acc only: -1
  - both: unchanged
  - neither: unchanged
  - Count never exceeds DEPTH and never underflows.
- Flags are registered and derived from the next-count value, so they are consistent with RXFIFO_RUSED_QWD in the same cycle.
- Simultaneous read and write when empty:
  - The read is rejected (no bypass).
  - The write is accepted.
  - Next cycle: count=1, EMPTY=0, RD_VALID=0.
- Simultaneous read and write when full: both accepted; count stays DEPTH and FULL stays 1.
- Read from empty: ignored; RD_VALID=0 and no state change.
- OVF_CLR:
  - Clears OVERFLOW and DROP_CNT to 0.
  - If wr_drop occurs in the same cycle, the drop wins: OVERFLOW=1, DROP_CNT=1.
- Ordering: strict FIFO; data emerges in write order across pointer wrap.

Test Plan:
1. Reset, then idle -> EMPTY=1, FULL=0, RUSED=0, RD_VALID=0, OVERFLOW=0, DROP_CNT=0.
2. Write 16 words 0x1..0x10 back-to-back, then RX_RE for 16 cycles:
   - RUSED steps 1..16; AFULL asserts at 12; FULL asserts after the 16th write.
   - RD_DATA returns 0x1..0x10 one cycle after each accept.
   - EMPTY=1 after the last read.
3. Fill to 16, then 3 more writes with RX_RE=0 -> RUSED=16, OVERFLOW=1, DROP_CNT=3. Pulse OVF_CLR -> both return to 0.
4. Full FIFO, RX_WE=RX_RE=1 with data 0xAA -> RUSED stays 16, oldest word is read, 0xAA is stored, no drop. Draining returns 0xAA last.
5. Empty FIFO, RX_WE=RX_RE=1 with 0x55 -> RD_VALID=0, RUSED=1. Next-cycle read returns 0x55.
6. Write 10 words, read 10, write 12 more (pointers wrap), then assert rst for 1 cycle mid-stream -> all outputs return to reset values. A subsequent write of 0x77 then read returns 0x77.
